f1_reaction_timer: RTL

F1_REACTION_TIMER -- requirements
Module: f1_reaction_timer

---
 rtl/f1_reaction_timer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/f1_reaction_timer.sv
// -----------------------------------------------------------------------------
// f1_reaction_timer
//
// Measures a driver's reaction time against an F1-style start-light bar.
// The sequencer lights the bar one lamp at a time (0x01, 0x03 ... 0xFF). When
// all lamps go dark (0x00) the race starts and the block counts 1 ms ticks
// until the driver presses the button. A press before lights-out is a jump
// start. If nobody presses, counting stops at TIMEOUT and the result is
// flagged as a timeout.
//
// Parameters
//   CNT_WIDTH  width of the reaction counter and of result_ms
//   TIMEOUT    tick count at which timing stops and timeout is raised
//
// Ports
//   clk         single clock, all state changes on its rising edge
//   rst         asynchronous, active-high reset
//   lights      thermometer-coded light bar from the start-light sequencer
//   tick        one-cycle 1 ms timebase strobe
//   btn         driver button, synchronous to clk, active-high
//   result_ms   latched reaction time in ticks (kept until the next result)
//   valid       one-cycle pulse when result_ms is latched
//   done        high while a completed measurement is held
//   jump_start  high while a jump start is held
//   timeout     high while a timed-out measurement is held
//   busy        high while a sequence is arming, all lamps are on, or timing
// -----------------------------------------------------------------------------
module f1_reaction_timer #(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 9999
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           lights,
  input  logic                 tick,
  input  logic                 btn,
  output logic [CNT_WIDTH-1:0] result_ms,
  output logic                 valid,
  output logic                 done,
  output logic                 jump_start,
  output logic                 timeout,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMING = 3'd1,
    S_ALL_ON = 3'd2,
    S_TIMING = 3'd3,
    S_DONE   = 3'd4,
    S_JUMP   = 3'd5
  } state_t;

  localparam logic [7:0]           LIGHTS_OFF   = 8'h00;
  localparam logic [7:0]           LIGHTS_FIRST = 8'h01;
  localparam logic [7:0]           LIGHTS_ALL   = 8'hFF;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C    = CNT_WIDTH'(TIMEOUT);

  // Registered state
  state_t               state;
  logic [7:0]           lights_q;
  logic                 btn_q;
  logic [CNT_WIDTH-1:0] count;

  // Next-state values
  state_t               state_n;
  logic [CNT_WIDTH-1:0] count_n;
  logic [CNT_WIDTH-1:0] result_n;
  logic                 valid_n;
  logic                 done_n;
  logic                 jump_n;
  logic                 timeout_n;

  logic                 press;
  logic [CNT_WIDTH-1:0] count_inc;
  logic                 new_sequence;

  // Rising edge of the (already synchronous) button.
  assign press        = btn & ~btn_q;
  assign count_inc    = count + CNT_WIDTH'(1);
  // A fresh sequence is the first lamp appearing after a dark bar; a bar that
  // simply stays at 0x01 does not re-arm a held result.
  assign new_sequence = (lights == LIGHTS_FIRST) && (lights_q == LIGHTS_OFF);

  assign busy = (state == S_ARMING) || (state == S_ALL_ON) || (state == S_TIMING);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lights_q   <= '0;
      btn_q      <= 1'b0;
      count      <= '0;
      result_ms  <= '0;
      valid      <= 1'b0;
      done       <= 1'b0;
      jump_start <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      lights_q   <= lights;
      btn_q      <= btn;
      count      <= count_n;
      result_ms  <= result_n;
      valid      <= valid_n;
      done       <= done_n;
      jump_start <= jump_n;
      timeout    <= timeout_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_n   = state;
    count_n   = count;
    result_n  = result_ms;
    valid_n   = 1'b0;
    done_n    = done;
    jump_n    = jump_start;
    timeout_n = timeout;

    case (state)
      S_IDLE: begin
        if (lights == LIGHTS_FIRST) begin
          state_n = S_ARMING;
        end
      end

      S_ARMING: begin
        if (press) begin
          state_n = S_JUMP;
          jump_n  = 1'b1;
        end else if (lights == LIGHTS_ALL) begin
          state_n = S_ALL_ON;
        end else if (lights == LIGHTS_OFF) begin
          // Sequencer abandoned the countdown before all lamps were lit.
          state_n = S_IDLE;
        end
      end

      S_ALL_ON: begin
        if (press) begin
          state_n = S_JUMP;
          jump_n  = 1'b1;
        end else if (lights == LIGHTS_OFF) begin
          state_n = S_TIMING;
          count_n = '0;
        end else if (lights != LIGHTS_ALL) begin
          state_n = S_IDLE;
        end
      end

      S_TIMING: begin
        if (press) begin
          // A press wins over a tick in the same cycle: the reaction is the
          // number of whole ticks seen before the button edge.
          state_n  = S_DONE;
          result_n = count;
          valid_n  = 1'b1;
          done_n   = 1'b1;
        end else if (lights != LIGHTS_OFF) begin
          // Lamps came back on: the sequencer restarted, discard this run.
          state_n = S_IDLE;
        end else if (tick) begin
          count_n = count_inc;
          if (count_inc == TIMEOUT_C) begin
            // Counter stops here; TIMING is left so it can never pass TIMEOUT.
            state_n   = S_DONE;
            result_n  = TIMEOUT_C;
            valid_n   = 1'b1;
            done_n    = 1'b1;
            timeout_n = 1'b1;
          end
        end
      end

      S_DONE, S_JUMP: begin
        // Hold the result and flags until the next sequence starts.
        if (new_sequence) begin
          state_n   = S_ARMING;
          done_n    = 1'b0;
          jump_n    = 1'b0;
          timeout_n = 1'b0;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
